// File: rtl/fifo_tx_drain.sv
// fifo_tx_drain: pulls words from the FIFO and serializes each one onto tx_out
// as start(0), data LSB-first, odd parity, stop(1), every bit held CLK_DIV cycles.
module fifo_tx_drain #(
    parameter int FIFO_WIDTH    = 64,
    parameter int CLK_DIV       = 4,
    parameter int WORD_CNT_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     read_n,
    input  logic [FIFO_WIDTH-1:0]    fifo_data,
    input  logic                     fifo_empty,
    input  logic                     tx_enable,
    output logic                     tx_out,
    output logic                     tx_busy,
    output logic [WORD_CNT_BITS-1:0] words_sent
);
    localparam int NBITS = FIFO_WIDTH + 3;
    localparam int BW    = $clog2(NBITS);
    localparam int DW    = $clog2(CLK_DIV + 1);

    typedef enum logic [1:0] {IDLE, READ, LOAD, SHIFT} state_t;

    state_t                state;
    logic [FIFO_WIDTH+1:0] shreg;
    logic [BW-1:0]         bit_cnt;
    logic [DW-1:0]         div_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            read_n     <= 1'b1;
            tx_out     <= 1'b1;
            tx_busy    <= 1'b0;
            words_sent <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (tx_enable && !fifo_empty) begin
                    state   <= READ;
                    read_n  <= 1'b0;
                    tx_busy <= 1'b1;
                end
                READ: begin
                    state  <= LOAD;
                    read_n <= 1'b1;
                end
                LOAD: begin
                    // shreg holds the bits that follow the start bit: data, parity, stop
                    shreg   <= {1'b1, ~^fifo_data, fifo_data};
                    tx_out  <= 1'b0;
                    bit_cnt <= '0;
                    div_cnt <= '0;
                    state   <= SHIFT;
                end
                SHIFT: if (div_cnt == DW'(CLK_DIV - 1)) begin
                    div_cnt <= '0;
                    if (bit_cnt == BW'(NBITS - 1)) begin
                        state      <= IDLE;
                        tx_busy    <= 1'b0;
                        words_sent <= words_sent + 1'b1;
                        bit_cnt    <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        tx_out  <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_tx_drain.sv
// tb_fifo_tx_drain: directed bench for fifo_tx_drain with a small FIFO model;
// a second narrow instance exercises words_sent wrap-around.
module tb_fifo_tx_drain;
    localparam int W = 64;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         read_n;
    logic [W-1:0] fifo_data;
    logic         fifo_empty;
    logic         tx_enable = 1'b0;
    logic         tx_out;
    logic         tx_busy;
    logic [15:0]  words_sent;

    logic         read_n2;
    logic         tx_enable2 = 1'b0;
    logic         tx_out2;
    logic         tx_busy2;
    logic [1:0]   words_sent2;
    logic [7:0]   fifo_data2 = 8'hA5;
    logic         fifo_empty2 = 1'b0;

    logic [W-1:0] mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int n_reads = 0;
    int empty_reads = 0;
    int total = 0;
    int bad = 0;
    int exp_ws = 0;

    fifo_tx_drain #(.FIFO_WIDTH(W), .CLK_DIV(D), .WORD_CNT_BITS(16)) dut (
        .clk(clk), .reset(reset), .read_n(read_n), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .tx_enable(tx_enable), .tx_out(tx_out),
        .tx_busy(tx_busy), .words_sent(words_sent)
    );

    fifo_tx_drain #(.FIFO_WIDTH(8), .CLK_DIV(1), .WORD_CNT_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .read_n(read_n2), .fifo_data(fifo_data2),
        .fifo_empty(fifo_empty2), .tx_enable(tx_enable2), .tx_out(tx_out2),
        .tx_busy(tx_busy2), .words_sent(words_sent2)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    // FIFO model: data changes on the edge that samples read_n low
    always @(posedge clk) begin
        if (read_n === 1'b0) begin
            if (rd_ptr == wr_ptr) empty_reads <= empty_reads + 1;
            fifo_data <= mem[rd_ptr[3:0]];
            rd_ptr    <= rd_ptr + 1;
            n_reads   <= n_reads + 1;
        end
    end

    task automatic push(input logic [W-1:0] w);
        mem[wr_ptr[3:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_read(input string name);
        bit found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (read_n === 1'b0) found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL %s: no read_n pulse within 400 cycles, got read_n=%b want 0", name, read_n);
        end
    endtask

    // Called at the negedge of the READ cycle; walks LOAD then the frame bits
    task automatic check_frame(input string name, input logic [W-1:0] w, input int drop_bit, input int abort_bit);
        logic [W+2:0] exp_f;
        int errs;
        exp_f = {1'b1, ~^w, w, 1'b0};
        @(negedge clk);
        total++;
        if ({read_n, tx_out, tx_busy} !== 3'b111) begin
            bad++;
            $display("FAIL %s load: got read_n/tx_out/tx_busy=%b want 111", name, {read_n, tx_out, tx_busy});
        end
        errs = 0;
        for (int b = 0; b < W + 3 && b != abort_bit; b++) begin
            for (int c = 0; c < D; c++) begin
                @(negedge clk);
                if (b == drop_bit && c == 0) tx_enable = 1'b0;
                if (tx_out !== exp_f[b] || tx_busy !== 1'b1 || read_n !== 1'b1) begin
                    if (errs == 0)
                        $display("FAIL %s frame bit %0d cycle %0d: got tx_out=%b busy=%b read_n=%b want tx_out=%b busy=1 read_n=1",
                                 name, b, c, tx_out, tx_busy, read_n, exp_f[b]);
                    errs++;
                end
            end
        end
        total++;
        if (errs != 0) bad++;
    endtask

    task automatic check_after(input string name);
        @(negedge clk);
        total++;
        if (words_sent !== 16'(exp_ws) || tx_busy !== 1'b0 || tx_out !== 1'b1) begin
            bad++;
            $display("FAIL %s end: got words_sent=%0d busy=%b tx_out=%b want %0d 0 1", name, words_sent, tx_busy, tx_out, exp_ws);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        total++;
        if ({read_n, tx_out, tx_busy, words_sent, words_sent2} !== {3'b110, 16'h0, 2'b00}) begin
            bad++;
            $display("FAIL reset: got read_n/tx_out/busy=%b ws=%0d ws2=%0d want 110 0 0",
                     {read_n, tx_out, tx_busy}, words_sent, words_sent2);
        end
        @(negedge clk);
        reset = 1'b0;
        tx_enable = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (n_reads !== 0 || read_n !== 1'b1 || tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL empty_idle: got reads=%0d read_n=%b busy=%b want 0 1 0", n_reads, read_n, tx_busy);
        end
    endtask

    task automatic test_single();
        push(64'h1);
        wait_read("single");
        check_frame("single", 64'h1, 999, 999);
        exp_ws = 1;
        check_after("single");
        repeat (5) @(negedge clk);
        total++;
        if (n_reads !== 1) begin
            bad++;
            $display("FAIL single reads: got %0d want 1", n_reads);
        end
    endtask

    task automatic test_parity();
        push(64'h0);
        push(64'hFFFF_FFFF_FFFF_FFFF);
        wait_read("zeros");
        check_frame("zeros", 64'h0, 999, 999);
        wait_read("ones");
        check_frame("ones", 64'hFFFF_FFFF_FFFF_FFFF, 999, 999);
        exp_ws = 3;
        check_after("parity");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w [3];
        int r0;
        w[0] = 64'h0123_4567_89AB_CDEF;
        w[1] = 64'h8000_0000_0000_0001;
        w[2] = 64'h0000_0000_0000_0003;
        r0 = n_reads;
        for (int k = 0; k < 3; k++) push(w[k]);
        wait_read("b2b0");
        check_frame("b2b0", w[0], 999, 999);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (read_n !== 1'b1 || tx_out !== 1'b1) begin
                bad++;
                $display("FAIL gap idle %0d: got read_n=%b tx_out=%b want 1 1", k, read_n, tx_out);
            end
            @(negedge clk);
            total++;
            if (read_n !== 1'b0 || tx_out !== 1'b1) begin
                bad++;
                $display("FAIL gap read %0d: got read_n=%b tx_out=%b want 0 1", k, read_n, tx_out);
            end
            check_frame("b2b", w[k], 999, 999);
        end
        exp_ws = 6;
        check_after("b2b");
        repeat (20) @(negedge clk);
        total++;
        if (n_reads - r0 !== 3 || empty_reads !== 0) begin
            bad++;
            $display("FAIL b2b reads: got reads=%0d empty_reads=%0d want 3 0", n_reads - r0, empty_reads);
        end
    endtask

    task automatic test_enable_drop();
        int r0;
        r0 = n_reads;
        push(64'hDEAD_BEEF_CAFE_F00D);
        push(64'h1234_0000_0000_5678);
        wait_read("drop");
        check_frame("drop", 64'hDEAD_BEEF_CAFE_F00D, 30, 999);
        exp_ws = 7;
        check_after("drop");
        repeat (20) @(negedge clk);
        total++;
        if (n_reads - r0 !== 1 || tx_busy !== 1'b0 || read_n !== 1'b1) begin
            bad++;
            $display("FAIL drop reads: got reads=%0d busy=%b read_n=%b want 1 0 1", n_reads - r0, tx_busy, read_n);
        end
    endtask

    task automatic test_mid_reset();
        int r0;
        tx_enable = 1'b1;
        wait_read("midrst");
        check_frame("midrst", 64'h1234_0000_0000_5678, 999, 20);
        #1 reset = 1'b1;
        #1;
        total++;
        if ({read_n, tx_out, tx_busy, words_sent} !== {3'b110, 16'h0}) begin
            bad++;
            $display("FAIL midrst: got read_n/tx_out/busy=%b ws=%0d want 110 0", {read_n, tx_out, tx_busy}, words_sent);
        end
        @(negedge clk);
        reset = 1'b0;
        r0 = n_reads;
        push(64'h5555_AAAA_0F0F_F0F1);
        wait_read("postrst");
        check_frame("postrst", 64'h5555_AAAA_0F0F_F0F1, 0, 999);
        exp_ws = 1;
        check_after("postrst");
        repeat (10) @(negedge clk);
        total++;
        if (n_reads - r0 !== 1) begin
            bad++;
            $display("FAIL postrst reads: got %0d want 1", n_reads - r0);
        end
    endtask

    task automatic test_wrap();
        int cnt = 0;
        bit done = 0;
        tx_enable2 = 1'b1;
        for (int i = 0; i < 400 && cnt < 5; i++) begin
            @(negedge clk);
            if (read_n2 === 1'b0) cnt++;
        end
        tx_enable2 = 1'b0;
        total++;
        if (cnt !== 5) begin
            bad++;
            $display("FAIL wrap reads: got %0d want 5", cnt);
        end
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (tx_busy2 === 1'b0) done = 1;
        end
        repeat (5) @(negedge clk);
        total++;
        if (words_sent2 !== 2'd1 || tx_busy2 !== 1'b0 || tx_out2 !== 1'b1) begin
            bad++;
            $display("FAIL wrap: got ws2=%0d busy2=%b tx_out2=%b want 1 0 1", words_sent2, tx_busy2, tx_out2);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_enable_drop();
        test_mid_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
